// File: rtl/solomon_video_pkg.sv
// solomon_video_pkg: default raster timing constants and the position type shared with the video stage
package solomon_video_pkg;

    localparam int H_TOTAL  = 384;
    localparam int H_ACTIVE = 256;
    localparam int HS_START = 304;
    localparam int HS_WIDTH = 32;
    localparam int V_TOTAL  = 264;
    localparam int V_ACTIVE = 224;
    localparam int VS_START = 240;
    localparam int VS_WIDTH = 3;

    typedef logic [8:0] pos_t;

endpackage

// File: rtl/solomon_hvgen_if.sv
// solomon_hvgen_if: raster bus between the timing generator (master) and the video stage (slave)
interface solomon_hvgen_if;
    import solomon_video_pkg::*;

    logic [3:0] HOFS;
    logic [3:0] VOFS;
    logic       PCE;
    pos_t       PH;
    pos_t       PV;
    logic       HBLK;
    logic       VBLK;
    logic       HSYNC;
    logic       VSYNC;
    logic       FRAME;

    modport master (
        input  HOFS, VOFS,
        output PCE, PH, PV, HBLK, VBLK, HSYNC, VSYNC, FRAME
    );

    modport slave (
        output HOFS, VOFS,
        input  PCE, PH, PV, HBLK, VBLK, HSYNC, VSYNC, FRAME
    );

endinterface

// File: rtl/solomon_hvgen_window.sv
// solomon_hvgen_window: in-window flag for a sync pulse; with SOLOMON_HVGEN_POSADJ_EN the start is shifted and clamped
module solomon_hvgen_window
    import solomon_video_pkg::*;
(
    input  pos_t       pos_i,
    input  pos_t       start_i,
    input  pos_t       width_i,
    input  pos_t       lo_i,
    input  pos_t       hi_i,
    input  logic [3:0] ofs_i,
    output logic       in_o
);

    pos_t start_c;

`ifdef SOLOMON_HVGEN_POSADJ_EN
    logic signed [9:0] raw;

    // signed sum keeps negative shifts ordered, then the clamp keeps sync inside blanking without wrapping
    always_comb begin
        raw     = $signed({1'b0, start_i}) + $signed({{6{ofs_i[3]}}, ofs_i});
        start_c = raw < $signed({1'b0, lo_i}) ? lo_i :
                  raw > $signed({1'b0, hi_i}) ? hi_i : raw[8:0];
    end
`else
    logic unused_adj;

    assign start_c    = start_i;
    assign unused_adj = ^{ofs_i, lo_i, hi_i};
`endif

    assign in_o = pos_i >= start_c && pos_i < start_c + width_i;

endmodule

// File: rtl/solomon_hvgen.sv
// solomon_hvgen: raster timing generator (PCE, PH/PV, blanking, sync, frame toggle) on the VCLKx4 domain.
// Build option SOLOMON_HVGEN_POSADJ_EN: HOFS/VOFS shift sync, latched at frame start and clamped into blanking.
module solomon_hvgen #(
    parameter int H_TOTAL  = solomon_video_pkg::H_TOTAL,
    parameter int H_ACTIVE = solomon_video_pkg::H_ACTIVE,
    parameter int HS_START = solomon_video_pkg::HS_START,
    parameter int HS_WIDTH = solomon_video_pkg::HS_WIDTH,
    parameter int V_TOTAL  = solomon_video_pkg::V_TOTAL,
    parameter int V_ACTIVE = solomon_video_pkg::V_ACTIVE,
    parameter int VS_START = solomon_video_pkg::VS_START,
    parameter int VS_WIDTH = solomon_video_pkg::VS_WIDTH
) (
    input  logic            VCLKx4,
    input  logic            RESET_N,
    solomon_hvgen_if.master bus
);
    import solomon_video_pkg::pos_t;

    logic [1:0] div_q, div_d;
    logic       pce_q, pce_d;
    pos_t       ph_q, ph_d;
    pos_t       pv_q, pv_d;
    logic       hblk_q, hblk_d;
    logic       vblk_q, vblk_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_q, frame_d;
    logic       line_end;
    logic       frame_end;
    logic [3:0] hofs_d;
    logic [3:0] vofs_d;

    // divider, pixel enable, raster advance; blanking decoded from the next position so it is aligned with PH/PV
    always_comb begin
        div_d     = div_q + 2'd1;
        pce_d     = div_q == 2'd3;
        line_end  = pce_q && ph_q == pos_t'(H_TOTAL - 1);
        frame_end = line_end && pv_q == pos_t'(V_TOTAL - 1);
        ph_d      = !pce_q ? ph_q : line_end ? '0 : ph_q + 9'd1;
        pv_d      = !line_end ? pv_q : frame_end ? '0 : pv_q + 9'd1;
        frame_d   = frame_q ^ frame_end;
        hblk_d    = ph_d >= pos_t'(H_ACTIVE);
        vblk_d    = pv_d >= pos_t'(V_ACTIVE);
    end

`ifdef SOLOMON_HVGEN_POSADJ_EN
    logic [3:0] hofs_q;
    logic [3:0] vofs_q;

    assign hofs_d = frame_end ? bus.HOFS : hofs_q;
    assign vofs_d = frame_end ? bus.VOFS : vofs_q;

    // offsets captured once per frame so the sync position never moves mid-frame
    always_ff @(posedge VCLKx4) begin
        if (!RESET_N) begin
            hofs_q <= '0;
            vofs_q <= '0;
        end else begin
            hofs_q <= hofs_d;
            vofs_q <= vofs_d;
        end
    end
`else
    assign hofs_d = bus.HOFS;
    assign vofs_d = bus.VOFS;
`endif

    solomon_hvgen_window u_hwin (
        .pos_i   (ph_d),
        .start_i (pos_t'(HS_START)),
        .width_i (pos_t'(HS_WIDTH)),
        .lo_i    (pos_t'(H_ACTIVE)),
        .hi_i    (pos_t'(H_TOTAL - HS_WIDTH)),
        .ofs_i   (hofs_d),
        .in_o    (hsync_d)
    );

    solomon_hvgen_window u_vwin (
        .pos_i   (pv_d),
        .start_i (pos_t'(VS_START)),
        .width_i (pos_t'(VS_WIDTH)),
        .lo_i    (pos_t'(V_ACTIVE)),
        .hi_i    (pos_t'(V_TOTAL - VS_WIDTH)),
        .ofs_i   (vofs_d),
        .in_o    (vsync_d)
    );

    // all timing state; reset clears everything so a mid-frame reset restarts exactly like power-up
    always_ff @(posedge VCLKx4) begin
        if (!RESET_N) begin
            div_q   <= '0;
            pce_q   <= 1'b0;
            ph_q    <= '0;
            pv_q    <= '0;
            hblk_q  <= 1'b0;
            vblk_q  <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            pce_q   <= pce_d;
            ph_q    <= ph_d;
            pv_q    <= pv_d;
            hblk_q  <= hblk_d;
            vblk_q  <= vblk_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            frame_q <= frame_d;
        end
    end

    assign bus.PCE   = pce_q;
    assign bus.PH    = ph_q;
    assign bus.PV    = pv_q;
    assign bus.HBLK  = hblk_q;
    assign bus.VBLK  = vblk_q;
    assign bus.HSYNC = hsync_q;
    assign bus.VSYNC = vsync_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_solomon_hvgen.sv
// tb_solomon_hvgen: scoreboard bench for a reduced-timing instance and a default-timing instance
module tb_solomon_hvgen;

    typedef struct packed {
        logic       pce;
        logic [8:0] ph;
        logic [8:0] pv;
        logic       hblk;
        logic       vblk;
        logic       hs;
        logic       vs;
        logic       frame;
    } obs_t;

    typedef struct packed {
        obs_t s;
        obs_t d;
    } exp_t;

`ifdef SOLOMON_HVGEN_POSADJ_EN
    localparam bit POSADJ = 1'b1;
`else
    localparam bit POSADJ = 1'b0;
`endif

    // reduced timing for the small instance, full default timing for the other
    localparam int SH_T = 40, SH_A = 24, SHS = 30, SHW = 4;
    localparam int SV_T = 20, SV_A = 12, SVS = 14, SVW = 3;
    localparam int DH_T = 384, DH_A = 256, DHS = 304, DHW = 32;
    localparam int DV_T = 264, DV_A = 224, DVS = 240, DVW = 3;
    localparam int S_FRAME = SH_T * SV_T * 4;

    logic clk = 1'b1;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int         n = 0;
    int         oh_s = 0, ov_s = 0, f_s = 0;
    int         oh_d = 0, ov_d = 0, f_d = 0;
    logic [3:0] cur_h = '0;
    logic [3:0] cur_v = '0;

    always #5 clk = ~clk;

    solomon_hvgen_if bus_s ();
    solomon_hvgen_if bus_d ();

    solomon_hvgen #(
        .H_TOTAL (SH_T), .H_ACTIVE(SH_A), .HS_START(SHS), .HS_WIDTH(SHW),
        .V_TOTAL (SV_T), .V_ACTIVE(SV_A), .VS_START(SVS), .VS_WIDTH(SVW)
    ) dut_s (
        .VCLKx4 (clk),
        .RESET_N(rst_n),
        .bus    (bus_s)
    );

    solomon_hvgen dut_d (
        .VCLKx4 (clk),
        .RESET_N(rst_n),
        .bus    (bus_d)
    );

    function automatic int place(int base, int ofs, int lo, int hi);
        int v = base + ofs;
        int c = v < lo ? lo : v > hi ? hi : v;
        return POSADJ ? c : base;
    endfunction

    function automatic int frame_of(int cyc, int ht, int vt);
        return cyc == 0 ? 0 : ((cyc - 1) / 4) / (ht * vt);
    endfunction

    // raster state after `cyc` clock edges since reset, from plain pixel arithmetic
    function automatic obs_t model(int cyc, int ht, int ha, int hs0, int hsw,
                                   int vt, int va, int vs0, int vsw, int oh, int ov);
        int   k    = cyc == 0 ? 0 : (cyc - 1) / 4;
        int   ph   = k % ht;
        int   line = k / ht;
        int   pv   = line % vt;
        int   hss  = place(hs0, oh, ha, ht - hsw);
        int   vss  = place(vs0, ov, va, vt - vsw);
        obs_t o;
        o.pce   = cyc >= 4 && cyc % 4 == 0;
        o.ph    = 9'(ph);
        o.pv    = 9'(pv);
        o.hblk  = ph >= ha;
        o.vblk  = pv >= va;
        o.hs    = ph >= hss && ph < hss + hsw;
        o.vs    = pv >= vss && pv < vss + vsw;
        o.frame = ((line / vt) % 2) == 1;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pce=%b ph=%0d pv=%0d hblk=%b vblk=%b hs=%b vs=%b frame=%b",
                         o.pce, o.ph, o.pv, o.hblk, o.vblk, o.hs, o.vs, o.frame);
    endfunction

    // drive one cycle of inputs and queue what both instances must show after the next edge
    task automatic cycle(input logic r, input logic [3:0] h, input logic [3:0] v);
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        bus_s.HOFS = h;
        bus_s.VOFS = v;
        bus_d.HOFS = h;
        bus_d.VOFS = v;
        if (!r) begin
            n = 0;
            oh_s = 0; ov_s = 0; f_s = 0;
            oh_d = 0; ov_d = 0; f_d = 0;
        end else begin
            n++;
            if (frame_of(n, SH_T, SV_T) != f_s) begin
                f_s  = frame_of(n, SH_T, SV_T);
                oh_s = int'($signed(h));
                ov_s = int'($signed(v));
            end
            if (frame_of(n, DH_T, DV_T) != f_d) begin
                f_d  = frame_of(n, DH_T, DV_T);
                oh_d = int'($signed(h));
                ov_d = int'($signed(v));
            end
        end
        e.s = model(n, SH_T, SH_A, SHS, SHW, SV_T, SV_A, SVS, SVW, oh_s, ov_s);
        e.d = model(n, DH_T, DH_A, DHS, DHW, DV_T, DV_A, DVS, DVW, oh_d, ov_d);
        q.push_back(e);
    endtask

    // one frame of the small raster with offsets starting at h/v and occasionally re-randomised
    task automatic run_frame(input logic [3:0] h, input logic [3:0] v);
        cur_h = h;
        cur_v = v;
        for (int i = 0; i < S_FRAME; i++) begin
            if ($urandom_range(0, 299) == 0) cur_h = 4'($urandom);
            if ($urandom_range(0, 299) == 0) cur_v = 4'($urandom);
            cycle(1'b1, cur_h, cur_v);
        end
    endtask

    // monitor: every edge both instances present a raster sample, compared against the queued model
    initial begin
        exp_t e;
        obs_t got_s, got_d;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue: sample at t=%0t has no expected entry", $time);
            end else begin
                e     = q.pop_front();
                got_s = {bus_s.PCE, bus_s.PH, bus_s.PV, bus_s.HBLK, bus_s.VBLK, bus_s.HSYNC, bus_s.VSYNC, bus_s.FRAME};
                got_d = {bus_d.PCE, bus_d.PH, bus_d.PV, bus_d.HBLK, bus_d.VBLK, bus_d.HSYNC, bus_d.VSYNC, bus_d.FRAME};
                checks++;
                if (got_s !== e.s) begin
                    errors++;
                    $display("FAIL small_raster t=%0t got {%s} exp {%s}", $time, fmt(got_s), fmt(e.s));
                end
                checks++;
                if (got_d !== e.d) begin
                    errors++;
                    $display("FAIL default_raster t=%0t got {%s} exp {%s}", $time, fmt(got_d), fmt(e.d));
                end
            end
        end
    end

    initial begin
        repeat (3) cycle(1'b0, 4'd0, 4'd0);
        run_frame(4'b1000, 4'd7);
        run_frame(4'd7, 4'b1000);
        run_frame(4'd0, 4'd0);
        for (int i = 0; i < 777; i++) cycle(1'b1, cur_h, cur_v);
        cycle(1'b0, cur_h, cur_v);
        run_frame(4'd3, 4'b1110);
        run_frame(4'b1000, 4'd7);
        run_frame(4'd7, 4'b1000);
        run_frame(4'($urandom), 4'($urandom));
        run_frame(4'($urandom), 4'($urandom));
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
